// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared widths and FSM encodings for the hazard controller
package hazard_ctrl_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int FLUSH_CNT_W    = 4;

    typedef enum logic [1:0] {
        HZ_RUN   = 2'd0,
        HZ_STALL = 2'd1,
        HZ_FLUSH = 2'd2
    } hz_state_e;

    // Counter value loaded on a redirect; the redirect cycle itself is the extra flush cycle.
    function automatic logic [FLUSH_CNT_W-1:0] flush_reload(input int cycles);
        return FLUSH_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_scoreboard.sv
// rtl/hazard_ctrl_scoreboard.sv - pending-write scoreboard with same-cycle writeback bypass
module hz_scoreboard
    import hazard_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set_en,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic                  clr_en,
    input  logic [ADDR_W-1:0]     clr_addr,
    input  logic [ADDR_W-1:0]     rs1,
    input  logic [ADDR_W-1:0]     rs2,
    input  logic [ADDR_W-1:0]     rd,
    output logic                  rs1_pend,
    output logic                  rs2_pend,
    output logic                  rd_pend,
    output logic [(1<<ADDR_W)-1:0] pend
);

    localparam int N = 1 << ADDR_W;

    logic [N-1:0] pend_q;
    logic [N-1:0] set_mask;
    logic [N-1:0] clr_mask;
    logic [N-1:0] pend_eff;

    // Decode set/clear requests; x0 can never become pending, and the writeback clear is
    // applied to the read view so a dependent instruction is released in the wb cycle.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (set_en) set_mask[set_addr] = 1'b1;
        if (clr_en) clr_mask[clr_addr] = 1'b1;
        set_mask[0] = 1'b0;
        pend_eff    = pend_q & ~clr_mask;
        pend_eff[0] = 1'b0;
    end

    // Update the pending bits; a set on the same register as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~clr_mask) | set_mask;
        end
    end

    assign rs1_pend = pend_eff[rs1];
    assign rs2_pend = pend_eff[rs2];
    assign rd_pend  = pend_eff[rd];
    assign pend     = pend_q;

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - FE/ID stall and flush sequencer driven by a long-latency scoreboard
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W   = DEF_REG_ADDR_W,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        id_valid,
    input  logic [REG_ADDR_W-1:0]       id_rs1,
    input  logic [REG_ADDR_W-1:0]       id_rs2,
    input  logic [REG_ADDR_W-1:0]       id_rd,
    input  logic                        id_use_rs1,
    input  logic                        id_use_rs2,
    input  logic                        id_long_wr,
    input  logic                        wb_valid,
    input  logic [REG_ADDR_W-1:0]       wb_rd,
    input  logic                        redirect,
    output logic                        stall_fe,
    output logic                        stall_id,
    output logic                        flush_fe,
    output logic                        flush_id,
    output logic [(1<<REG_ADDR_W)-1:0]  pending
);

    localparam logic [FLUSH_CNT_W-1:0] CNT_RELOAD = flush_reload(FLUSH_CYCLES);

    hz_state_e              state;
    logic [FLUSH_CNT_W-1:0] cnt;
    logic                   rs1_pend;
    logic                   rs2_pend;
    logic                   rd_pend;
    logic                   hit;
    logic                   flush;
    logic                   stall;
    logic                   issue;

    hz_scoreboard #(
        .ADDR_W (REG_ADDR_W)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (issue),
        .set_addr (id_rd),
        .clr_en   (wb_valid),
        .clr_addr (wb_rd),
        .rs1      (id_rs1),
        .rs2      (id_rs2),
        .rd       (id_rd),
        .rs1_pend (rs1_pend),
        .rs2_pend (rs2_pend),
        .rd_pend  (rd_pend),
        .pend     (pending)
    );

    // Hazard detection and output decode; a redirect flushes in its own cycle and masks any stall.
    always_comb begin
        hit   = id_valid & ((id_use_rs1 & rs1_pend) |
                            (id_use_rs2 & rs2_pend) |
                            (id_long_wr & rd_pend));
        flush = redirect | (state == HZ_FLUSH);
        stall = hit & ~flush;
        issue = id_valid & id_long_wr & ~stall & ~flush;
    end

    assign stall_fe = stall;
    assign stall_id = stall;
    assign flush_fe = flush;
    assign flush_id = flush;

    // Sequencer state and flush counter; a redirect in any state (re)starts the flush burst.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= HZ_RUN;
            cnt   <= '0;
        end else if (redirect) begin
            state <= HZ_FLUSH;
            cnt   <= CNT_RELOAD;
        end else begin
            case (state)
                HZ_RUN: begin
                    if (hit) state <= HZ_STALL;
                end
                HZ_STALL: begin
                    if (!hit) state <= HZ_RUN;
                end
                HZ_FLUSH: begin
                    if (cnt == '0) state <= HZ_RUN;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= HZ_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard-checked bench for hazard_ctrl
module tb_hazard_ctrl;

    localparam int AW = 5;
    localparam int FC = 2;

    typedef struct packed {
        logic        stall_fe;
        logic        stall_id;
        logic        flush_fe;
        logic        flush_id;
        logic [31:0] pending;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [AW-1:0] id_rs1;
    logic [AW-1:0] id_rs2;
    logic [AW-1:0] id_rd;
    logic          id_use_rs1;
    logic          id_use_rs2;
    logic          id_long_wr;
    logic          wb_valid;
    logic [AW-1:0] wb_rd;
    logic          redirect;
    logic          stall_fe;
    logic          stall_id;
    logic          flush_fe;
    logic          flush_id;
    logic [31:0]   pending;

    int checks   = 0;
    int failures = 0;

    exp_t        exp_q[$];
    logic [31:0] m_pend;
    int          m_state;
    int          m_cnt;

    hazard_ctrl #(
        .REG_ADDR_W   (AW),
        .FLUSH_CYCLES (FC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .id_valid   (id_valid),
        .id_rs1     (id_rs1),
        .id_rs2     (id_rs2),
        .id_rd      (id_rd),
        .id_use_rs1 (id_use_rs1),
        .id_use_rs2 (id_use_rs2),
        .id_long_wr (id_long_wr),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .redirect   (redirect),
        .stall_fe   (stall_fe),
        .stall_id   (stall_id),
        .flush_fe   (flush_fe),
        .flush_id   (flush_id),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_state = 0;
        m_cnt   = 0;
    endtask

    // One cycle: drive inputs after the edge, predict, compare at negedge, advance the model.
    task automatic step(input logic v, input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                        input logic [AW-1:0] rd, input logic u1, input logic u2, input logic lw,
                        input logic wbv, input logic [AW-1:0] wbrd, input logic redir);
        logic [31:0] eff;
        logic [31:0] np;
        logic        hit;
        logic        fl;
        logic        st;
        logic        iss;
        exp_t        e;
        exp_t        got;
        id_valid = v;  id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_use_rs1 = u1; id_use_rs2 = u2; id_long_wr = lw;
        wb_valid = wbv; wb_rd = wbrd; redirect = redir;
        eff = m_pend;
        if (wbv) eff[wbrd] = 1'b0;
        eff[0] = 1'b0;
        hit = v & ((u1 & eff[rs1]) | (u2 & eff[rs2]) | (lw & eff[rd]));
        fl  = redir | (m_state == 2);
        st  = hit & ~fl;
        iss = v & lw & ~st & ~fl;
        e.stall_fe = st; e.stall_id = st; e.flush_fe = fl; e.flush_id = fl; e.pending = m_pend;
        exp_q.push_back(e);
        @(negedge clk);
        got = exp_q.pop_front();
        chk("stall_fe", {31'd0, stall_fe}, {31'd0, got.stall_fe});
        chk("stall_id", {31'd0, stall_id}, {31'd0, got.stall_id});
        chk("flush_fe", {31'd0, flush_fe}, {31'd0, got.flush_fe});
        chk("flush_id", {31'd0, flush_id}, {31'd0, got.flush_id});
        chk("pending",  pending, got.pending);
        np = m_pend;
        if (wbv) np[wbrd] = 1'b0;
        if (iss && rd != '0) np[rd] = 1'b1;
        m_pend = np;
        if (redir) begin
            m_state = 2;
            m_cnt   = FC - 1;
        end else if (m_state == 0) begin
            if (hit) m_state = 1;
        end else if (m_state == 1) begin
            if (!hit) m_state = 0;
        end else begin
            if (m_cnt == 0) m_state = 0;
            else            m_cnt   = m_cnt - 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        id_valid = 0; id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0; id_long_wr = 0;
        wb_valid = 0; wb_rd = 0; redirect = 0;
        model_reset();
        #12;
        chk("rst_stall_id", {31'd0, stall_id}, 32'd0);
        chk("rst_flush_id", {31'd0, flush_id}, 32'd0);
        chk("rst_pending", pending, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // load-use on r5, released in the writeback cycle
        step(1, 0, 0, 5, 0, 0, 1, 0, 0, 0);
        step(1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 5, 0, 1, 1, 0, 0, 0, 0, 0);
        step(1, 5, 0, 1, 1, 0, 0, 1, 5, 0);
        idle();

        // x0 is never pending
        step(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 2, 1, 1, 0, 0, 0, 0);
        idle();

        // redirect during a stall on r7
        step(1, 0, 0, 7, 0, 0, 1, 0, 0, 0);
        step(1, 0, 7, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 7, 1, 0, 1, 0, 0, 0, 1);
        step(1, 0, 7, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 7, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 7, 1, 0, 1, 0, 0, 0, 0);
        step(1, 0, 7, 1, 0, 1, 0, 1, 7, 0);
        idle();

        // same-cycle writeback and issue on r9: set wins
        step(1, 0, 0, 9, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 9, 0, 0, 1, 1, 9, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1, 11, 0);

        // WAW on r3
        step(1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 3, 0, 0, 1, 1, 3, 0);
        idle();
        step(0, 0, 0, 0, 0, 0, 0, 1, 3, 0);

        // flushed issue never sets; redirect inside a flush reloads the counter
        step(1, 0, 0, 10, 0, 0, 1, 0, 0, 1);
        step(1, 0, 0, 10, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle();
        idle();
        idle();

        // reset in the middle of a flush with r4 and r12 pending
        step(1, 0, 0, 4, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 12, 0, 0, 1, 0, 0, 0);
        step(1, 4, 0, 1, 1, 0, 0, 0, 0, 1);
        id_valid = 0; id_long_wr = 0; id_use_rs1 = 0; redirect = 0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_flush_fe", {31'd0, flush_fe}, 32'd0);
        chk("midrst_flush_id", {31'd0, flush_id}, 32'd0);
        chk("midrst_stall_fe", {31'd0, stall_fe}, 32'd0);
        chk("midrst_pending", pending, 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle();

        // random traffic on a narrow register range
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0),
                 AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 2) == 0), AW'($urandom_range(0, 7)),
                 1'($urandom_range(0, 15) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
